// File: rtl/fdd_head_positioner_if.sv
// FDC-side pin bundle for the head positioner: drive select, step/direction,
// per-drive motor and media status in, selected-drive status and seek strobes out.
interface fdd_head_positioner_if #(
  parameter int NUM_DRIVES = 2
);
  localparam int SEL_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;

  // No valid/ready pair here: STEPn is a level pin whose falling edge is the
  // request, and seek_done is an unconditional one-clk strobe per drive.
  logic [SEL_W-1:0]      USEL;
  logic                  STEPn;
  logic                  SDIRn;
  logic [NUM_DRIVES-1:0] MOTORn;
  logic [NUM_DRIVES-1:0] disk_mounted;
  logic [NUM_DRIVES-1:0] disk_readonly;
  logic [6:0]            track;
  logic                  TRACK0n;
  logic                  READYn;
  logic                  INDEXn;
  logic                  WPROTn;
  logic                  seek_busy;
  logic [NUM_DRIVES-1:0] seek_done;

  modport master (
    output USEL, STEPn, SDIRn, MOTORn, disk_mounted, disk_readonly,
    input  track, TRACK0n, READYn, INDEXn, WPROTn, seek_busy, seek_done
  );

  modport slave (
    input  USEL, STEPn, SDIRn, MOTORn, disk_mounted, disk_readonly,
    output track, TRACK0n, READYn, INDEXn, WPROTn, seek_busy, seek_done
  );
endinterface

// File: rtl/fdd_head_positioner.sv
// N-drive floppy head positioner: per-drive cylinder, step-rate timer,
// spin-up counter and rotation counter, with status muxed by USEL.
module fdd_head_positioner #(
  parameter int NUM_DRIVES = 2,
  parameter int MAX_TRACKS = 80,
  parameter int STEP_MS    = 3,
  parameter int SPINUP_MS  = 100,
  parameter int ROT_MS     = 200,
  parameter int INDEX_MS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  msclk,
  fdd_head_positioner_if.slave  fdc
);
  localparam int SEL_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
  localparam logic [6:0]       CYL_MAX  = 7'(MAX_TRACKS - 1);
  localparam logic [7:0]       STEP_LD  = 8'(STEP_MS);
  localparam logic [9:0]       SPIN_MAX = 10'(SPINUP_MS);
  localparam logic [9:0]       ROT_LAST = 10'(ROT_MS - 1);
  localparam logic [9:0]       IDX_LEN  = 10'(INDEX_MS);
  localparam logic [SEL_W:0]   DRV_CNT  = NUM_DRIVES[SEL_W:0];

  logic [6:0] cyl      [NUM_DRIVES];
  logic [7:0] step_tmr [NUM_DRIVES];
  logic [9:0] spin_cnt [NUM_DRIVES];
  logic [9:0] rot_cnt  [NUM_DRIVES];

  logic                  stepn_s;
  logic                  last_stepn;
  logic                  step_edge;
  logic                  step_in;
  logic                  step_out;
  logic [SEL_W-1:0]      sel;
  logic [NUM_DRIVES-1:0] step_load;
  logic [NUM_DRIVES-1:0] seek_done_q;

  // An out-of-range select falls back to drive 0 rather than indexing past the arrays.
  assign sel       = ({1'b0, fdc.USEL} < DRV_CNT) ? fdc.USEL : '0;
  assign step_edge = last_stepn & ~stepn_s;

  always_comb begin
    step_in   = 1'b0;
    step_out  = 1'b0;
    step_load = '0;
    // Edges that arrive while the selected drive is still settling are dropped.
    if (step_edge && (step_tmr[sel] == 8'd0)) begin
      if (fdc.SDIRn && (cyl[sel] < CYL_MAX)) begin
        step_in = 1'b1;
      end else if (!fdc.SDIRn && (cyl[sel] != 7'd0)) begin
        step_out = 1'b1;
      end
    end
    for (int d = 0; d < NUM_DRIVES; d++) begin
      step_load[d] = (step_in || step_out) && (sel == SEL_W'(d));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stepn_s     <= 1'b1;
      last_stepn  <= 1'b1;
      seek_done_q <= '0;
      for (int d = 0; d < NUM_DRIVES; d++) begin
        cyl[d]      <= '0;
        step_tmr[d] <= '0;
        spin_cnt[d] <= '0;
        rot_cnt[d]  <= '0;
      end
    end else begin
      stepn_s    <= fdc.STEPn;
      last_stepn <= stepn_s;
      for (int d = 0; d < NUM_DRIVES; d++) begin
        if (step_load[d]) begin
          cyl[d]      <= step_in ? (cyl[d] + 7'd1) : (cyl[d] - 7'd1);
          step_tmr[d] <= STEP_LD;
        end else if (msclk && (step_tmr[d] != 8'd0)) begin
          step_tmr[d] <= step_tmr[d] - 8'd1;
        end
        // A loaded drive had a zero timer, so a 1->0 transition never collides with a load.
        seek_done_q[d] <= msclk && (step_tmr[d] == 8'd1);

        if (fdc.MOTORn[d]) begin
          spin_cnt[d] <= '0;
        end else if (msclk && (spin_cnt[d] != SPIN_MAX)) begin
          spin_cnt[d] <= spin_cnt[d] + 10'd1;
        end

        if (fdc.MOTORn[d] || !fdc.disk_mounted[d]) begin
          rot_cnt[d] <= '0;
        end else if (msclk) begin
          rot_cnt[d] <= (rot_cnt[d] == ROT_LAST) ? 10'd0 : (rot_cnt[d] + 10'd1);
        end
      end
    end
  end

  assign fdc.track     = cyl[sel];
  assign fdc.TRACK0n   = (cyl[sel] != 7'd0);
  assign fdc.READYn    = !((spin_cnt[sel] == SPIN_MAX) && fdc.disk_mounted[sel]);
  assign fdc.INDEXn    = !(!fdc.MOTORn[sel] && fdc.disk_mounted[sel] && (rot_cnt[sel] < IDX_LEN));
  assign fdc.WPROTn    = !(fdc.disk_mounted[sel] && fdc.disk_readonly[sel]);
  assign fdc.seek_busy = (step_tmr[sel] != 8'd0);
  assign fdc.seek_done = seek_done_q;
endmodule
